// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, trial
// subtraction built as A + ~B + 1 on a ripple chain of full-adder cells.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request accepted on any rising edge where busy is
  // low; done then stays high with stable results until the next accepted start.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] p_q, p_n;
  logic [WIDTH-1:0] dvd_q, dvd_n;
  logic [WIDTH-1:0] dvs_q, dvs_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] quot_n, rem_n;
  logic             busy_n, done_n, dz_n;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             no_borrow;
  logic [WIDTH-1:0] quot_shift;

  assign state_dbg = state_q;

  // The stored partial remainder is always below the divisor, so its top bit
  // is implied zero; only the shifted trial operand carries the extra bit.
  assign shifted    = {p_q, dvd_q[WIDTH-1]};
  assign quot_shift = {dvd_q[WIDTH-2:0], no_borrow};

  // Ripple subtractor: shifted - {0, divisor}, carry-in 1, carry-out = no borrow.
  always_comb begin
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = shifted[i] ^ ~dvs_q[i] ^ carry;
      carry   = (shifted[i] & ~dvs_q[i]) | (carry & (shifted[i] ^ ~dvs_q[i]));
    end
    // Top cell adds ~0 = 1, so its carry-out reduces to a OR carry-in.
    no_borrow = shifted[WIDTH] | carry;
  end

  always_comb begin
    state_n = state_q;
    p_n     = p_q;
    dvd_n   = dvd_q;
    dvs_n   = dvs_q;
    cnt_n   = cnt_q;
    quot_n  = quotient;
    rem_n   = remainder;
    busy_n  = busy;
    done_n  = done;
    dz_n    = div_zero;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_n   = dividend;
            dvs_n   = divisor;
            p_n     = '0;
            cnt_n   = '0;
            done_n  = 1'b0;
            dz_n    = 1'b0;
            busy_n  = 1'b1;
            state_n = RUN;
          end else begin
            quot_n  = '1;
            rem_n   = dividend;
            dz_n    = 1'b1;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = FIN;
          end
        end
      end
      RUN: begin
        // The dividend register shifts out numerator bits and shifts in quotient bits.
        p_n   = no_borrow ? diff : shifted[WIDTH-1:0];
        dvd_n = quot_shift;
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_n  = quot_shift;
          rem_n   = p_n;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = FIN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      p_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state_q   <= state_n;
      p_q       <= p_n;
      dvd_q     <= dvd_n;
      dvs_q     <= dvs_n;
      cnt_q     <= cnt_n;
      quotient  <= quot_n;
      remainder <= rem_n;
      busy      <= busy_n;
      done      <= done_n;
      div_zero  <= dz_n;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios plus a randomized exhaustive sweep
// checked against plain integer division.
module tb_seq_divider;

  localparam int W        = 4;
  localparam int MAX_WAIT = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [1:0]   state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
  end

  // Output-combination checks every cycle
  always @(negedge clk) begin
    checks = checks + 1;
    if (busy === 1'b1 && done === 1'b1) begin
      failures = failures + 1;
      $display("FAIL flags_busy_done busy=%b done=%b required not both high", busy, done);
    end
    checks = checks + 1;
    if (div_zero === 1'b1 && done !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL flags_dz_without_done div_zero=%b done=%b", div_zero, done);
    end
  end

  // driver tasks (called at a negedge, return at the negedge after the accept edge)
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom_range(0, 15);
    divisor  = $urandom_range(0, 15);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < MAX_WAIT) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({quotient, remainder, busy, done, div_zero} !== '0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset q=%0d r=%0d b=%b d=%b z=%b st=%0d required all 0",
               quotient, remainder, busy, done, div_zero, state_dbg);
    end
  endtask

  task automatic test_basic();
    int busy_cycles;
    drive_start(4'd13, 4'd3);
    busy_cycles = 0;
    for (int i = 0; i < MAX_WAIT && done !== 1'b1; i++) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != W) begin
      failures++;
      $display("FAIL basic_busy_len got=%0d required=%0d", busy_cycles, W);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_13_3 d=%b b=%b q=%0d r=%0d z=%b required d=1 b=0 q=4 r=1 z=0",
               done, busy, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    drive_start(4'd15, 4'd1);
    wait_done(edges);
    checks++;
    if (edges != W || quotient !== 4'd15 || remainder !== 4'd0) begin
      failures++;
      $display("FAIL b2b_first lat=%0d q=%0d r=%0d required lat=%0d q=15 r=0",
               edges, quotient, remainder, W);
    end
    drive_start(4'd2, 4'd7);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || quotient !== 4'd15 || remainder !== 4'd0) begin
      failures++;
      $display("FAIL b2b_accept d=%b b=%b q=%0d r=%0d required d=0 b=1 q=15 r=0",
               done, busy, quotient, remainder);
    end
    wait_done(edges);
    checks++;
    if (edges != W || quotient !== 4'd0 || remainder !== 4'd2) begin
      failures++;
      $display("FAIL b2b_second lat=%0d q=%0d r=%0d required lat=%0d q=0 r=2",
               edges, quotient, remainder, W);
    end
  endtask

  task automatic test_div_zero();
    bit saw_busy;
    drive_start(4'd9, 4'd0);
    saw_busy = (busy === 1'b1);
    checks++;
    if (done !== 1'b1 || div_zero !== 1'b1 || quotient !== 4'd15 || remainder !== 4'd9 || saw_busy) begin
      failures++;
      $display("FAIL div_zero d=%b z=%b q=%0d r=%0d b=%b required d=1 z=1 q=15 r=9 b=0",
               done, div_zero, quotient, remainder, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL div_zero_hold d=%b z=%b b=%b required d=1 z=1 b=0", done, div_zero, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int edges;
    drive_start(4'd12, 4'd5);
    drive_start(4'd7, 4'd7);
    wait_done(edges);
    checks++;
    if (edges != W - 1 || quotient !== 4'd2 || remainder !== 4'd2 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL start_while_busy lat=%0d q=%0d r=%0d z=%b required lat=%0d q=2 r=2 z=0",
               edges, quotient, remainder, div_zero, W - 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    drive_start(4'd14, 4'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({quotient, remainder, busy, done, div_zero} !== '0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_run q=%0d r=%0d b=%b d=%b z=%b st=%0d required all 0",
               quotient, remainder, busy, done, div_zero, state_dbg);
    end
    @(negedge clk);
    drive_start(4'd14, 4'd3);
    wait_done(edges);
    checks++;
    if (edges != W || quotient !== 4'd4 || remainder !== 4'd2) begin
      failures++;
      $display("FAIL after_reset_14_3 lat=%0d q=%0d r=%0d required lat=%0d q=4 r=2",
               edges, quotient, remainder, W);
    end
  endtask

  // Exhaustive sweep in random order, with random idle gaps (0 = back-to-back)
  // and a few random divide-by-zero requests mixed in.
  task automatic test_sweep();
    logic [2*W-1:0] pairs[$];
    logic [2*W-1:0] tmp;
    logic [2*W-1:0] exp;
    logic [W-1:0]   a, b;
    int             j, edges, exp_lat;
    int             bad = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 1; y < 16; y++)
        pairs.push_back({x[W-1:0], y[W-1:0]});
    for (int i = 0; i < 20; i++) pairs.push_back({4'($urandom_range(0, 15)), 4'd0});
    for (int i = pairs.size() - 1; i > 0; i--) begin
      j        = $urandom_range(0, i);
      tmp      = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = tmp;
    end
    foreach (pairs[k]) begin
      a = pairs[k][2*W-1:W];
      b = pairs[k][W-1:0];
      if (b == 0) exp_q.push_back({4'hF, a});
      else exp_q.push_back({4'(int'(a) / int'(b)), 4'(int'(a) % int'(b))});
      exp_lat = (b == 0) ? 0 : W;
      drive_start(a, b);
      wait_done(edges);
      exp = exp_q.pop_front();
      checks++;
      if (edges != exp_lat || {quotient, remainder} !== exp || div_zero !== (b == 0)) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep %0d/%0d lat=%0d q=%0d r=%0d z=%b required lat=%0d q=%0d r=%0d z=%b",
                   a, b, edges, quotient, remainder, div_zero, exp_lat,
                   exp[2*W-1:W], exp[W-1:0], (b == 0));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_div_zero();
    test_start_while_busy();
    @(negedge clk);
    test_reset_mid_run();
    @(negedge clk);
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
